piso_out_ctrl: RTL

Sequencer for the PISO_OUT output serializer of the NPU-MNIST classifier. It accepts a "results ready" request from the classifier core and loads the NUM_TAPS-word result vector into PISO_OUT. It then streams the words one at a time to the external host over a valid/ready handshake, pausing the shift whenever the host stalls. It also owns PISO_OUT's clear, enable and shift controls, which no other block drives.

---
 rtl/npu_pkg.sv | 15 +
 rtl/piso_out.sv | 29 ++
 rtl/piso_out_ctrl.sv | 101 ++++++++++
 3 files changed

// File: rtl/npu_pkg.sv
// Shared NPU-MNIST definitions: PISO_OUT geometry and the output-sequencer FSM states.
// Used by both the sequencer and the serializer so their word size and vector length always match.
package npu_pkg;

  localparam int NPU_OUT_WIDTH    = 8;
  localparam int NPU_OUT_NUM_TAPS = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SEND  = 2'd2,
    ST_FLUSH = 2'd3
  } piso_ctrl_state_t;

endpackage

// File: rtl/piso_out.sv
// PISO_OUT: parallel-in/serial-out result register; EN&!SHIFT loads, EN&SHIFT drops word 0.
// One-cycle load/shift latency; no backpressure of its own, the sequencer gates EN.
module piso_out
  import npu_pkg::*;
#(
  parameter int WIDTH    = NPU_OUT_WIDTH,
  parameter int NUM_TAPS = NPU_OUT_NUM_TAPS
) (
  input  logic                      CLK,
  input  logic                      CLR,
  input  logic                      EN,
  input  logic                      SHIFT,
  input  logic [WIDTH*NUM_TAPS-1:0] DATA_IN,
  output logic [WIDTH-1:0]          DATA_OUT
);

  logic [WIDTH*NUM_TAPS-1:0] r_sr;

  always_ff @(posedge CLK) begin
    if (CLR) begin
      r_sr <= '0;
    end else if (EN) begin
      r_sr <= SHIFT ? {{WIDTH{1'b0}}, r_sr[WIDTH*NUM_TAPS-1:WIDTH]} : DATA_IN;
    end
  end

  assign DATA_OUT = r_sr[WIDTH-1:0];

endmodule

// File: rtl/piso_out_ctrl.sv
// Sequencer for PISO_OUT: loads a result vector on START, streams it word 0 first over OUT_VALID/OUT_READY.
// Word 0 valid two cycles after START; a stalled host holds the current word (no shift) until accepted.
module piso_out_ctrl
  import npu_pkg::*;
#(
  parameter int WIDTH    = NPU_OUT_WIDTH,
  parameter int NUM_TAPS = NPU_OUT_NUM_TAPS
) (
  input  logic             CLKEXT,
  input  logic             RST_N,
  input  logic             START,
  input  logic             ABORT,
  input  logic             OUT_READY,
  input  logic [WIDTH-1:0] PISO_DATA,
  output logic             CLR_PISO_OUT,
  output logic             EN_PISO_OUT,
  output logic             SHIFT_OUT,
  output logic             OUT_VALID,
  output logic [WIDTH-1:0] OUT_DATA,
  output logic             OUT_LAST,
  output logic             BUSY,
  output logic             DONE
);

  localparam int                CNT_W    = $clog2(NUM_TAPS);
  localparam logic [CNT_W-1:0]  LAST_IDX = CNT_W'(NUM_TAPS - 1);

  piso_ctrl_state_t r_state;
  piso_ctrl_state_t w_state_nxt;
  logic [CNT_W-1:0] r_idx;
  logic             r_done;
  logic             w_xfer;
  logic             w_last;

  assign w_last = (r_idx == LAST_IDX);
  assign w_xfer = (r_state == ST_SEND) && !ABORT && OUT_READY;

  always_ff @(posedge CLKEXT or negedge RST_N) begin
    if (!RST_N) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // A START still held during FLUSH chains straight into the next LOAD.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (START && !ABORT) w_state_nxt = ST_LOAD;
      ST_LOAD:  w_state_nxt = ABORT ? ST_FLUSH : ST_SEND;
      ST_SEND:  if (ABORT || (w_xfer && w_last)) w_state_nxt = ST_FLUSH;
      ST_FLUSH: w_state_nxt = (START && !ABORT) ? ST_LOAD : ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLKEXT or negedge RST_N) begin
    if (!RST_N) begin
      r_idx  <= '0;
      r_done <= 1'b0;
    end else begin
      r_done <= w_xfer && w_last;
      if (r_state == ST_LOAD) begin
        r_idx <= '0;
      end else if (w_xfer && !w_last) begin
        r_idx <= r_idx + CNT_W'(1);
      end
    end
  end

  // Serializer stays cleared for the whole time reset is asserted.
  always_comb begin
    CLR_PISO_OUT = !RST_N;
    EN_PISO_OUT  = 1'b0;
    SHIFT_OUT    = 1'b0;
    OUT_VALID    = 1'b0;
    OUT_LAST     = 1'b0;
    DONE         = 1'b0;
    BUSY         = (r_state != ST_IDLE);
    case (r_state)
      ST_LOAD: begin
        EN_PISO_OUT = !ABORT;
      end
      ST_SEND: begin
        OUT_VALID   = !ABORT;
        OUT_LAST    = w_last;
        EN_PISO_OUT = w_xfer && !w_last;
        SHIFT_OUT   = w_xfer && !w_last;
      end
      ST_FLUSH: begin
        CLR_PISO_OUT = 1'b1;
        DONE         = r_done;
      end
      default: ;
    endcase
  end

  assign OUT_DATA = OUT_VALID ? PISO_DATA : '0;

endmodule
